// File: rtl/myproject_dense_mac_sched_pkg.sv
// Shared types and widths for the resource-shared dense-layer MAC sequencer.
package myproject_dense_mac_sched_pkg;

    localparam int X_W = 16;
    localparam int W_W = 8;
    localparam int P_W = 24;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

endpackage

// File: rtl/myproject_dense_mac_sched.sv
// Walks input/weight memories through one external shared 16x8 multiplier,
// accumulating one output neuron at a time and writing each result out.
module myproject_dense_mac_sched
    import myproject_dense_mac_sched_pkg::*;
#(
    parameter int N_IN  = 16,
    parameter int N_OUT = 8,
    parameter int ACC_W = 32,
    parameter int X_AW  = (N_IN > 1) ? $clog2(N_IN) : 1,
    parameter int W_AW  = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1,
    parameter int R_AW  = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    input  logic             ap_start,
    output logic             ap_done,
    output logic             ap_idle,
    output logic             ap_ready,
    output logic [X_AW-1:0]  x_addr,
    output logic             x_ce,
    input  logic [X_W-1:0]   x_q,
    output logic [W_AW-1:0]  w_addr,
    output logic             w_ce,
    input  logic [W_W-1:0]   w_q,
    output logic [X_W-1:0]   mul_a,
    output logic [W_W-1:0]   mul_b,
    input  logic [P_W-1:0]   mul_p,
    output logic [R_AW-1:0]  res_addr,
    output logic [ACC_W-1:0] res_d,
    output logic             res_we
);

    localparam logic [X_AW-1:0] I_LAST = X_AW'(N_IN - 1);
    localparam logic [R_AW-1:0] J_LAST = R_AW'(N_OUT - 1);

    state_t            state_q, state_d;
    logic [X_AW-1:0]   i_q, i_d;
    logic [R_AW-1:0]   j_q, j_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              d1_q;
    logic              issue;

    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        acc_d   = acc_q;
        issue   = 1'b0;
        res_we  = 1'b0;
        ap_done = 1'b0;
        ap_idle = 1'b0;

        // The product of the read issued last cycle lands this cycle.
        if (d1_q) begin
            acc_d = acc_q + ACC_W'($signed(mul_p));
        end

        unique case (state_q)
            S_IDLE: begin
                ap_idle = 1'b1;
                if (ap_start) begin
                    state_d = S_ISSUE;
                    i_d     = '0;
                    j_d     = '0;
                    acc_d   = '0;
                end
            end
            S_ISSUE: begin
                issue = 1'b1;
                if (i_q == I_LAST) begin
                    state_d = S_DRAIN;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            S_DRAIN: begin
                state_d = S_WRITE;
            end
            S_WRITE: begin
                res_we = 1'b1;
                acc_d  = '0;
                i_d    = '0;
                if (j_q == J_LAST) begin
                    state_d = S_DONE;
                end else begin
                    j_d     = j_q + 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_DONE: begin
                ap_done = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            acc_q   <= '0;
            d1_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            acc_q   <= acc_d;
            d1_q    <= issue;
        end
    end

    assign ap_ready = ap_done;
    assign x_ce     = issue;
    assign w_ce     = issue;
    assign x_addr   = issue ? i_q : '0;
    assign w_addr   = issue ? W_AW'(int'(j_q) * N_IN + int'(i_q)) : '0;
    assign mul_a    = d1_q ? x_q : '0;
    assign mul_b    = d1_q ? w_q : '0;
    assign res_addr = res_we ? j_q : '0;
    assign res_d    = res_we ? acc_q : '0;

endmodule

// File: tb/tb_myproject_dense_mac_sched.sv
// Bench: two instances (32-bit and 24-bit accumulators) run in lockstep on shared
// memories; results are compared against a plain dot-product model.
module tb_myproject_dense_mac_sched;

    localparam int N_IN  = 4;
    localparam int N_OUT = 2;
    localparam int ACC_A = 32;
    localparam int ACC_B = 24;
    localparam int X_AW  = 2;
    localparam int W_AW  = 3;
    localparam int R_AW  = 1;
    localparam int LAT   = N_OUT * (N_IN + 2) + 1;

    logic clk;
    logic rst;
    logic start;

    logic             done_a, idle_a, ready_a, x_ce_a, w_ce_a, res_we_a;
    logic [X_AW-1:0]  x_addr_a;
    logic [W_AW-1:0]  w_addr_a;
    logic [15:0]      x_q_a = '0;
    logic [7:0]       w_q_a = '0;
    logic [15:0]      mul_a_a;
    logic [7:0]       mul_b_a;
    logic [23:0]      mul_p_a;
    logic [R_AW-1:0]  res_addr_a;
    logic [ACC_A-1:0] res_d_a;

    logic             done_b, idle_b, ready_b, x_ce_b, w_ce_b, res_we_b;
    logic [X_AW-1:0]  x_addr_b;
    logic [W_AW-1:0]  w_addr_b;
    logic [15:0]      x_q_b = '0;
    logic [7:0]       w_q_b = '0;
    logic [15:0]      mul_a_b;
    logic [7:0]       mul_b_b;
    logic [23:0]      mul_p_b;
    logic [R_AW-1:0]  res_addr_b;
    logic [ACC_B-1:0] res_d_b;

    logic [15:0] x_mem [N_IN];
    logic [7:0]  w_mem [N_IN*N_OUT];

    int n_checks = 0;
    int n_err    = 0;

    myproject_dense_mac_sched #(
        .N_IN(N_IN), .N_OUT(N_OUT), .ACC_W(ACC_A),
        .X_AW(X_AW), .W_AW(W_AW), .R_AW(R_AW)
    ) dut_a (
        .ap_clk(clk), .ap_rst(rst), .ap_start(start),
        .ap_done(done_a), .ap_idle(idle_a), .ap_ready(ready_a),
        .x_addr(x_addr_a), .x_ce(x_ce_a), .x_q(x_q_a),
        .w_addr(w_addr_a), .w_ce(w_ce_a), .w_q(w_q_a),
        .mul_a(mul_a_a), .mul_b(mul_b_a), .mul_p(mul_p_a),
        .res_addr(res_addr_a), .res_d(res_d_a), .res_we(res_we_a)
    );

    myproject_dense_mac_sched #(
        .N_IN(N_IN), .N_OUT(N_OUT), .ACC_W(ACC_B),
        .X_AW(X_AW), .W_AW(W_AW), .R_AW(R_AW)
    ) dut_b (
        .ap_clk(clk), .ap_rst(rst), .ap_start(start),
        .ap_done(done_b), .ap_idle(idle_b), .ap_ready(ready_b),
        .x_addr(x_addr_b), .x_ce(x_ce_b), .x_q(x_q_b),
        .w_addr(w_addr_b), .w_ce(w_ce_b), .w_q(w_q_b),
        .mul_a(mul_a_b), .mul_b(mul_b_b), .mul_p(mul_p_b),
        .res_addr(res_addr_b), .res_d(res_d_b), .res_we(res_we_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memories and the shared signed multipliers.
    always @(posedge clk) begin
        if (x_ce_a) x_q_a <= x_mem[x_addr_a];
        if (w_ce_a) w_q_a <= w_mem[w_addr_a];
        if (x_ce_b) x_q_b <= x_mem[x_addr_b];
        if (w_ce_b) w_q_b <= w_mem[w_addr_b];
    end

    assign mul_p_a = 24'(int'($signed(mul_a_a)) * int'($signed(mul_b_a)));
    assign mul_p_b = 24'(int'($signed(mul_a_b)) * int'($signed(mul_b_b)));

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: full-precision dot product of neuron j; callers keep the low ACC_W bits.
    function automatic logic [63:0] exp_sum(input int j);
        longint s = 0;
        for (int i = 0; i < N_IN; i++) begin
            s += longint'($signed(x_mem[i])) * longint'($signed(w_mem[j*N_IN + i]));
        end
        return 64'(s);
    endfunction

    task automatic fill_random();
        for (int i = 0; i < N_IN; i++) x_mem[i] = 16'($urandom);
        for (int k = 0; k < N_IN*N_OUT; k++) w_mem[k] = 8'($urandom);
    endtask

    // Presents ap_start in an IDLE cycle (counted as cycle 0) and checks the run to ap_done.
    task automatic run_job(input string tag, input bit hold, input bit skip_wait, input int poke_at);
        int c = 0;
        int issue_n = 0;
        int wr_n = 0;
        int guard = 0;
        bit finished = 1'b0;
        logic [63:0] s;
        if (!skip_wait) begin
            @(negedge clk);
            while (!idle_a && guard < 50) begin
                @(negedge clk);
                guard++;
            end
        end
        check({tag, " idle_at_start"}, 64'(idle_a), 64'd1);
        start = 1'b1;
        while (!finished && c < LAT + 20) begin
            @(negedge clk);
            c++;
            if (!hold) start = (c == poke_at);
            if (c == 1) check({tag, " first_issue"}, 64'(x_ce_a), 64'd1);
            if (x_ce_a) begin
                check({tag, " x_addr"}, 64'(x_addr_a), 64'(issue_n % N_IN));
                check({tag, " w_addr"}, 64'(w_addr_a), 64'(issue_n));
                issue_n++;
            end
            if (res_we_a && wr_n < N_OUT) begin
                s = exp_sum(wr_n);
                check({tag, " res_addr"}, 64'(res_addr_a), 64'(wr_n));
                check({tag, " res_d32"}, 64'(res_d_a), 64'(s[31:0]));
                check({tag, " res_we24"}, 64'(res_we_b), 64'd1);
                check({tag, " res_d24"}, 64'(res_d_b), 64'(s[23:0]));
                wr_n++;
            end
            if (done_a) begin
                check({tag, " latency"}, 64'(c), 64'(LAT));
                check({tag, " ready"}, 64'(ready_a), 64'd1);
                check({tag, " done24"}, 64'(done_b), 64'd1);
                check({tag, " issues"}, 64'(issue_n), 64'(N_IN*N_OUT));
                check({tag, " writes"}, 64'(wr_n), 64'(N_OUT));
                finished = 1'b1;
            end
        end
        if (!finished) check({tag, " timeout"}, 64'd0, 64'd1);
    endtask

    // Counts ap_done/res_we/x_ce activity over a quiet window.
    task automatic expect_quiet(input string tag, input int cycles);
        int ev = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (done_a || res_we_a || x_ce_a || done_b || res_we_b) ev++;
        end
        check({tag, " quiet"}, 64'(ev), 64'd0);
    endtask

    initial begin
        int c;
        rst   = 1'b1;
        start = 1'b0;
        for (int i = 0; i < N_IN; i++) x_mem[i] = '0;
        for (int k = 0; k < N_IN*N_OUT; k++) w_mem[k] = '0;
        #7;
        check("rst idle", 64'(idle_a), 64'd1);
        check("rst done", 64'(done_a), 64'd0);
        check("rst ready", 64'(ready_a), 64'd0);
        check("rst x_ce", 64'(x_ce_a), 64'd0);
        check("rst w_ce", 64'(w_ce_a), 64'd0);
        check("rst res_we", 64'(res_we_a), 64'd0);
        check("rst res_d", 64'(res_d_a), 64'd0);
        check("rst mul_a", 64'(mul_a_a), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Ramp inputs, unit weights: 1+2+3+4 = 10 for both neurons.
        for (int i = 0; i < N_IN; i++) x_mem[i] = 16'(i + 1);
        for (int k = 0; k < N_IN*N_OUT; k++) w_mem[k] = 8'd1;
        check("ramp model", exp_sum(0), 64'd10);
        run_job("ramp", 1'b0, 1'b0, 0);
        start = 1'b0;

        // Signed extremes: 4194304 + 4161409 + 128 + 0 = 0x7F8001.
        x_mem[0] = 16'h8000; x_mem[1] = 16'h7FFF; x_mem[2] = 16'hFFFF; x_mem[3] = 16'h0000;
        for (int j = 0; j < N_OUT; j++) begin
            w_mem[j*N_IN + 0] = 8'h80;
            w_mem[j*N_IN + 1] = 8'h7F;
            w_mem[j*N_IN + 2] = 8'h80;
            w_mem[j*N_IN + 3] = 8'h05;
        end
        run_job("signed", 1'b0, 1'b0, 0);
        start = 1'b0;

        // Max positive products overflow the 24-bit accumulator.
        for (int i = 0; i < N_IN; i++) x_mem[i] = 16'h7FFF;
        for (int k = 0; k < N_IN*N_OUT; k++) w_mem[k] = 8'h7F;
        run_job("wrap", 1'b0, 1'b0, 0);
        start = 1'b0;

        for (int r = 0; r < 4; r++) begin
            fill_random();
            run_job("random", 1'b0, 1'b0, 0);
            start = 1'b0;
        end

        // ap_start pulses while busy must be ignored.
        fill_random();
        run_job("busy5", 1'b0, 1'b0, 5);
        start = 1'b0;
        expect_quiet("busy5", 20);
        fill_random();
        run_job("busy9", 1'b0, 1'b0, 9);
        start = 1'b0;
        expect_quiet("busy9", 20);

        // ap_start held high: exactly one IDLE cycle between runs.
        fill_random();
        run_job("b2b0", 1'b1, 1'b0, 0);
        @(negedge clk);
        check("b2b gap idle", 64'(idle_a), 64'd1);
        check("b2b gap x_ce", 64'(x_ce_a), 64'd0);
        fill_random();
        run_job("b2b1", 1'b1, 1'b1, 0);
        start = 1'b0;

        // Reset in the middle of neuron 1's issue phase.
        fill_random();
        @(negedge clk);
        check("mrst idle_at_start", 64'(idle_a), 64'd1);
        start = 1'b1;
        c = 0;
        while (c < 8) begin
            @(negedge clk);
            c++;
            start = 1'b0;
        end
        check("mrst pre x_ce", 64'(x_ce_a), 64'd1);
        check("mrst pre w_addr", 64'(w_addr_a), 64'(N_IN + 1));
        #2 rst = 1'b1;
        #1;
        check("mrst idle", 64'(idle_a), 64'd1);
        check("mrst x_ce", 64'(x_ce_a), 64'd0);
        check("mrst w_addr", 64'(w_addr_a), 64'd0);
        check("mrst mul_a", 64'(mul_a_a), 64'd0);
        check("mrst res_we", 64'(res_we_a), 64'd0);
        check("mrst done", 64'(done_a), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        expect_quiet("mrst", 20);
        fill_random();
        run_job("post_rst", 1'b0, 1'b0, 0);
        start = 1'b0;

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
